// File: rtl/collision_controller.sv
// Collision-buffer sequencer: two-stage read/compare/write pixel pipeline plus full-buffer clear sweep.
// Optional: define COLL_FIRST_WINS_EN to keep the first sprite's ownership on a collision.
module collision_controller #(
  parameter int ADDR_WIDTH = 10,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [ADDR_WIDTH-1:0] pix_x,
  input  logic [ID_WIDTH-1:0]   pix_id,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  clear_done,
  output logic                  coll_valid,
  output logic [ID_WIDTH-1:0]   coll_new_id,
  output logic [ID_WIDTH-1:0]   coll_old_id,
  output logic [7:0]            coll_count,
  input  logic                  count_clr,
  output logic [ADDR_WIDTH-1:0] buf_addr_a,
  output logic                  buf_wr_a,
  output logic [ID_WIDTH:0]     buf_wr_data_a,
  input  logic [ID_WIDTH:0]     buf_rd_data_a,
  output logic [ADDR_WIDTH-1:0] buf_addr_b,
  output logic                  buf_wr_b,
  output logic [ID_WIDTH:0]     buf_wr_data_b,
  output logic [1:0]            state_dbg
);

  localparam int DATA_WIDTH = ID_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic                    s1_valid;
  logic [ADDR_WIDTH-1:0]   s1_x;
  logic [ID_WIDTH-1:0]     s1_id;
  logic                    fw_valid;
  logic [ADDR_WIDTH-1:0]   fw_x;
  logic [DATA_WIDTH-1:0]   fw_data;
  logic [DATA_WIDTH-1:0]   old_word;
  logic [DATA_WIDTH-1:0]   s1_word;
  logic [DATA_WIDTH-1:0]   retained;
  logic                    hit;
  logic                    s1_wr;
  logic                    accept;

  // Pixel handshake: a pixel transfers on a cycle where pix_valid and pix_ready are both high;
  // pix_ready never depends on pix_valid, and the renderer holds pix_x/pix_id while stalled.
  assign pix_ready = (state == IDLE) & ~clear_req & ~reset;
  assign accept    = pix_valid & pix_ready;

  assign buf_addr_a    = pix_x;
  assign buf_wr_a      = 1'b0;
  assign buf_wr_data_a = '0;
  assign busy          = (state != IDLE);
  assign state_dbg     = state;

  // The buffer returns stale data when reading the address written the cycle before,
  // so the previous stage-1 result is forwarded instead.
  assign s1_word  = {1'b1, s1_id};
  assign old_word = (fw_valid && (fw_x == s1_x)) ? fw_data : buf_rd_data_a;
  assign hit      = s1_valid & old_word[ID_WIDTH] & (old_word[ID_WIDTH-1:0] != s1_id);

`ifdef COLL_FIRST_WINS_EN
  assign s1_wr    = s1_valid & ~hit;
  assign retained = hit ? old_word : s1_word;
`else
  assign s1_wr    = s1_valid;
  assign retained = s1_word;
`endif

  always_comb begin
    state_next    = state;
    buf_wr_b      = 1'b0;
    buf_addr_b    = s1_x;
    buf_wr_data_b = '0;
    unique case (state)
      IDLE: begin
        if (clear_req) state_next = FLUSH;
        buf_wr_b      = s1_wr;
        buf_wr_data_b = s1_valid ? s1_word : '0;
      end
      FLUSH: state_next = CLEAR;
      CLEAR: begin
        buf_wr_b   = 1'b1;
        buf_addr_b = clr_cnt;
        if (clr_cnt == LAST_ADDR) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (reset) buf_wr_b = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      clr_cnt     <= '0;
      s1_valid    <= 1'b0;
      s1_x        <= '0;
      s1_id       <= '0;
      fw_valid    <= 1'b0;
      fw_x        <= '0;
      fw_data     <= '0;
      clear_done  <= 1'b0;
      coll_valid  <= 1'b0;
      coll_new_id <= '0;
      coll_old_id <= '0;
      coll_count  <= '0;
    end else begin
      state      <= state_next;
      clear_done <= (state == CLEAR) && (clr_cnt == LAST_ADDR);
      if (state == CLEAR) clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
      s1_valid <= accept;
      if (accept) begin
        s1_x  <= pix_x;
        s1_id <= pix_id;
      end
      fw_valid   <= s1_valid;
      fw_x       <= s1_x;
      fw_data    <= retained;
      coll_valid <= hit;
      if (hit) begin
        coll_new_id <= s1_id;
        coll_old_id <= old_word[ID_WIDTH-1:0];
      end
      // A clear request wins over a simultaneous increment.
      if (count_clr) coll_count <= '0;
      else if (hit && (coll_count != 8'hFF)) coll_count <= coll_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_collision_controller.sv
// Bench for collision_controller: buffer memory model, vector table, hand sequences and random pixels
// checked against an in-order pixel ownership model with an expected-event queue.
module tb_collision_controller;

  localparam int AW    = 10;
  localparam int IW    = 8;
  localparam int DW    = 9;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [AW-1:0] pix_x = '0;
  logic [IW-1:0] pix_id = '0;
  logic          clear_req = 1'b0;
  logic          busy, clear_done, coll_valid;
  logic [IW-1:0] coll_new_id, coll_old_id;
  logic [7:0]    coll_count;
  logic          count_clr = 1'b0;
  logic [AW-1:0] buf_addr_a, buf_addr_b;
  logic          buf_wr_a, buf_wr_b;
  logic [DW-1:0] buf_wr_data_a, buf_rd_data_a, buf_wr_data_b;
  logic [1:0]    state_dbg;

  collision_controller #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clk(clk), .reset(reset),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_id(pix_id),
    .clear_req(clear_req), .busy(busy), .clear_done(clear_done),
    .coll_valid(coll_valid), .coll_new_id(coll_new_id), .coll_old_id(coll_old_id),
    .coll_count(coll_count), .count_clr(count_clr),
    .buf_addr_a(buf_addr_a), .buf_wr_a(buf_wr_a), .buf_wr_data_a(buf_wr_data_a),
    .buf_rd_data_a(buf_rd_data_a),
    .buf_addr_b(buf_addr_b), .buf_wr_b(buf_wr_b), .buf_wr_data_b(buf_wr_data_b),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- collision buffer memory (registered read, old data on collision) ----------------
  function automatic logic [DW-1:0] garbage(input int i);
    return {1'b1, 8'(i * 7)};
  endfunction

  logic [DW-1:0] mem [DEPTH];
  bit filled = 1'b0;
  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= garbage(i);
      filled <= 1'b1;
    end else begin
      if (buf_wr_a) mem[buf_addr_a] <= buf_wr_data_a;
      if (buf_wr_b) mem[buf_addr_b] <= buf_wr_data_b;
    end
    buf_rd_data_a <= mem[buf_addr_a];
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0]   ref_mem [DEPTH];
  logic [2*IW-1:0] exp_q[$];
  int              exp_cyc_q[$];
  int              ref_count = 0;
  int              ev_seen = 0;
  bit              clr_prev = 1'b0;
  bit              rst_prev = 1'b0;
  bit              ev_due;
  logic [2*IW-1:0] exp_ids;

  always @(negedge clk) begin
    ev_due = 1'b0;
    if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) ev_due = 1'b1;
    if (coll_valid === 1'b1) ev_seen++;
    if (ev_due) begin
      exp_ids = exp_q.pop_front();
      void'(exp_cyc_q.pop_front());
      chk("coll_valid", 32'(coll_valid), 1);
      chk("coll_new_id", 32'(coll_new_id), 32'(exp_ids[2*IW-1:IW]));
      chk("coll_old_id", 32'(coll_old_id), 32'(exp_ids[IW-1:0]));
    end else if (coll_valid === 1'b1) begin
      chk("coll_spurious", 32'(coll_valid), 0);
    end
    if (rst_prev || clr_prev) ref_count = 0;
    else if (ev_due && ref_count < 255) ref_count++;
    if (rst_prev || clr_prev || ev_due) chk("coll_count", 32'(coll_count), 32'(ref_count));
    clr_prev = count_clr;
    rst_prev = reset;
  end

  // Pixels are applied to the ownership map in acceptance order; an event is due two cycles later.
  task automatic model_accept(input logic [AW-1:0] x, input logic [IW-1:0] id);
    logic [DW-1:0] old;
    bit collide;
    old = ref_mem[x];
    collide = old[IW] && (old[IW-1:0] != id);
    if (collide) begin
      exp_q.push_back({id, old[IW-1:0]});
      exp_cyc_q.push_back(cyc + 2);
    end
`ifdef COLL_FIRST_WINS_EN
    if (!collide) ref_mem[x] = {1'b1, id};
`else
    ref_mem[x] = {1'b1, id};
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input bit v, input logic [AW-1:0] x, input logic [IW-1:0] id, input bit cclr);
    tick();
    pix_valid = v;
    pix_x     = x;
    pix_id    = id;
    clear_req = 1'b0;
    count_clr = cclr;
    if (v) model_accept(x, id);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [AW-1:0] x1;
    logic [IW-1:0] id1;
    logic [AW-1:0] x2;
    logic [IW-1:0] id2;
    bit            b2b;
    int            exp_ev;
    logic [DW-1:0] exp_lw;
    logic [DW-1:0] exp_fw;
  } vec_t;

  vec_t          vecs[10];
  int            ev0;
  int            errs;
  logic [DW-1:0] exp_word;

  initial begin
    vecs[0] = '{10'd5,    8'd3,    10'd9,    8'd7,    1'b0, 0, 9'h107, 9'h107};
    vecs[1] = '{10'd5,    8'd3,    10'd5,    8'd7,    1'b0, 1, 9'h107, 9'h103};
    vecs[2] = '{10'd40,   8'd3,    10'd40,   8'd3,    1'b0, 0, 9'h103, 9'h103};
    vecs[3] = '{10'd20,   8'd1,    10'd20,   8'd2,    1'b1, 1, 9'h102, 9'h101};
    vecs[4] = '{10'd50,   8'd9,    10'd50,   8'd9,    1'b1, 0, 9'h109, 9'h109};
    vecs[5] = '{10'd60,   8'd0,    10'd61,   8'd0,    1'b1, 0, 9'h100, 9'h100};
    vecs[6] = '{10'd70,   8'hFF,   10'd70,   8'hFE,   1'b1, 1, 9'h1FE, 9'h1FF};
    vecs[7] = '{10'd1023, 8'd4,    10'd1023, 8'd5,    1'b0, 1, 9'h105, 9'h104};
    vecs[8] = '{10'd0,    8'h80,   10'd0,    8'h80,   1'b1, 0, 9'h180, 9'h180};
    vecs[9] = '{10'd20,   8'd2,    10'd20,   8'd1,    1'b1, 1, 9'h101, 9'h101};

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = garbage(i);

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_pix_ready_low", 32'(pix_ready), 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_clear_done", 32'(clear_done), 0);
    chk("rst_coll_valid", 32'(coll_valid), 0);
    chk("rst_buf_wr_b", 32'(buf_wr_b), 0);
    chk("rst_coll_new_id", 32'(coll_new_id), 0);
    chk("rst_coll_old_id", 32'(coll_old_id), 0);
    chk("rst_coll_count", 32'(coll_count), 0);
    chk("rst_buf_addr_b", 32'(buf_addr_b), 0);
    chk("rst_buf_wr_data_b", 32'(buf_wr_data_b), 0);
    chk("rst_buf_wr_a", 32'(buf_wr_a), 0);
    chk("idle_pix_ready", 32'(pix_ready), 1);

    // Clear with a pixel still in stage 1
    cycle(1'b1, 10'd100, 8'hBC, 1'b0);
    tick();
    pix_valid = 1'b0;
    clear_req = 1'b1;
    @(negedge clk);
    chk("flight_wr_en", 32'(buf_wr_b), 1);
    chk("flight_wr_addr", 32'(buf_addr_b), 100);
    chk("flight_wr_data", 32'(buf_wr_data_b), 'h1BC);
    chk("req_pix_ready_low", 32'(pix_ready), 0);
    tick();
    clear_req = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(busy), 1);
    chk("flush_no_write", 32'(buf_wr_b), 0);
    chk("flush_pix_ready_low", 32'(pix_ready), 0);
    errs = 0;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      @(negedge clk);
      if (!(buf_wr_b === 1'b1 && buf_addr_b === AW'(i) && buf_wr_data_b === '0 &&
            busy === 1'b1 && pix_ready === 1'b0 && clear_done === 1'b0)) errs++;
    end
    chk("clear_sweep_errors", 32'(errs), 0);
    tick();
    @(negedge clk);
    chk("clear_done_pulse", 32'(clear_done), 1);
    chk("clear_end_busy", 32'(busy), 0);
    chk("clear_end_pix_ready", 32'(pix_ready), 1);
    tick();
    @(negedge clk);
    chk("clear_done_single", 32'(clear_done), 0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // Table-driven pixel pairs
    for (int i = 0; i < 10; i++) begin
      ev0 = ev_seen;
      cycle(1'b1, vecs[i].x1, vecs[i].id1, 1'b0);
      if (!vecs[i].b2b) idle(1);
      cycle(1'b1, vecs[i].x2, vecs[i].id2, 1'b0);
      idle(3);
      @(negedge clk);
      chk($sformatf("vec%0d_events", i), 32'(ev_seen - ev0), 32'(vecs[i].exp_ev));
`ifdef COLL_FIRST_WINS_EN
      exp_word = vecs[i].exp_fw;
`else
      exp_word = vecs[i].exp_lw;
`endif
      chk($sformatf("vec%0d_mem", i), 32'(mem[vecs[i].x2]), 32'(exp_word));
      if (i == 0) chk("vec0_mem_x1", 32'(mem[5]), 'h103);
    end

    // Saturation, then count_clr racing an increment
    for (int i = 0; i < 310; i++) cycle(1'b1, 10'd200, 8'((i % 255) + 1), 1'b0);
    idle(3);
    @(negedge clk);
    chk("count_saturated", 32'(coll_count), 255);
    cycle(1'b1, 10'd200, 8'h00, 1'b0);
    cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    chk("clr_vs_event_valid", 32'(coll_valid), 1);
    chk("clr_vs_event_count", 32'(coll_count), 0);
    idle(2);

    // Reset while a colliding pixel sits in stage 1
    cycle(1'b1, 10'd300, 8'd4, 1'b0);
    idle(3);
    tick();
    pix_valid = 1'b1;
    pix_x     = 10'd300;
    pix_id    = 8'd5;
    tick();
    pix_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    chk("rst_pixel_no_write", 32'(buf_wr_b), 0);
    chk("rst_pixel_ready_low", 32'(pix_ready), 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_pixel_no_event", 32'(coll_valid), 0);
    idle(1);
    cycle(1'b1, 10'd300, 8'd5, 1'b0);
    idle(3);

    // Randomized pixels over a small window to force frequent overlaps
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 3) != 0, 10'(400 + $urandom_range(0, 15)),
            8'($urandom_range(0, 3)), $urandom_range(0, 40) == 0);
    idle(4);
    @(negedge clk);
    for (int a = 400; a < 416; a++)
      chk($sformatf("rand_mem_%0d", a), 32'(mem[a]), 32'(ref_mem[a]));

    // Reset in the middle of a clear sweep
    tick();
    pix_valid = 1'b0;
    count_clr = 1'b0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (501) tick();
    reset = 1'b1;
    @(negedge clk);
    chk("abort_counter_addr", 32'(buf_addr_b), 500);
    chk("abort_busy_before", 32'(busy), 1);
    chk("abort_pix_ready_low", 32'(pix_ready), 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_no_write", 32'(buf_wr_b), 0);
    chk("abort_no_clear_done", 32'(clear_done), 0);
    tick();
    @(negedge clk);
    chk("abort_no_clear_done_late", 32'(clear_done), 0);
    chk("abort_pix_ready", 32'(pix_ready), 1);
    for (int i = 0; i < 500; i++) ref_mem[i] = '0;
    cycle(1'b1, 10'd600, 8'h22, 1'b0);
    #1;
    chk("post_abort_accept_ready", 32'(pix_ready), 1);
    tick();
    pix_valid = 1'b0;
    @(negedge clk);
    chk("post_abort_wr_en", 32'(buf_wr_b), 1);
    chk("post_abort_wr_addr", 32'(buf_addr_b), 600);
    chk("post_abort_wr_data", 32'(buf_wr_data_b), 'h122);
    idle(3);
    @(negedge clk);
    chk("post_abort_mem", 32'(mem[600]), 'h122);
    chk("exp_queue_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/collision_controller.md
Name: collision_controller

Overview:
- Sequences the dual-port 1Kx9 collision buffer for one scanline of sprite pixels.
- Per pixel: reads the buffer entry at the pixel's X position, detects overlap with a different sprite, and writes the new owner.
- On request, sweeps the whole buffer to zero between lines.
- Sits between the sprite renderer and the collision buffer. Reports collision pairs to the register/CPU interface.

Parameters:
- ADDR_WIDTH, 10, buffer address width; buffer depth is 2^ADDR_WIDTH entries.
- ID_WIDTH, 8, sprite index width. Buffer word = {occupied bit, id}, so DATA_WIDTH = ID_WIDTH+1 = 9.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_valid  in  1  renderer has a pixel
- pix_ready  out  1  controller accepts a pixel this cycle
- pix_x  in  ADDR_WIDTH  pixel X / buffer address
- pix_id  in  ID_WIDTH  sprite index owning the pixel
- clear_req  in  1  request a full buffer clear
- busy  out  1  high in FLUSH/CLEAR
- clear_done  out  1  one-cycle pulse when the clear completes
- coll_valid  out  1  one-cycle collision event
- coll_new_id  out  ID_WIDTH  sprite being drawn
- coll_old_id  out  ID_WIDTH  sprite already present
- coll_count  out  8  saturating collision counter
- count_clr  in  1  zero coll_count
- buf_addr_a  out  ADDR_WIDTH  buffer port A address (read port)
- buf_wr_a  out  1  tied 0; port A never writes
- buf_wr_data_a  out  ID_WIDTH+1  tied 0
- buf_rd_data_a  in  ID_WIDTH+1  port A read data, registered, 1-cycle latency
- buf_addr_b  out  ADDR_WIDTH  buffer port B address (write port)
- buf_wr_b  out  1  port B write enable
- buf_wr_data_b  out  ID_WIDTH+1  port B write data

Behaviour:
- **Reset values:** pix_ready=0 during reset. busy, clear_done, coll_valid, buf_wr_b = 0. coll_new_id, coll_old_id, coll_count, buf_addr_b, buf_wr_data_b = 0. State=IDLE, stage-1 valid=0, clear counter=0.
- **States:**
  - IDLE: pixel processing.
  - FLUSH: 1 cycle; lets the in-flight stage-1 write retire.
  - CLEAR: 2^ADDR_WIDTH cycles.
- **Transitions:**
  - IDLE and clear_req=1 → FLUSH.
  - FLUSH → CLEAR.
  - CLEAR at counter = 2^ADDR_WIDTH-1 → IDLE; clear_done pulses in the first IDLE cycle.
  - clear_req is ignored outside IDLE.
- **pix_ready** = (state==IDLE) & !clear_req & !reset.
- **Accept** = pix_valid & pix_ready.
- **Stage 0 (cycle N, accept):** buf_addr_a = pix_x combinationally. Register x and id into stage 1, set stage1_valid.
- **Stage 1 (cycle N+1):**
  - old = buf_rd_data_a, except forwarded from the previous stage-1 write data when the previous stage-1 was valid at the same address. The buffer returns old data on read-during-write.
  - buf_wr_b=1, buf_addr_b=x, buf_wr_data_b={1,id}; all three driven from registers.
- **Collision:** old[ID_WIDTH]=1 and old id != new id.
  - Registered: coll_valid=1 in cycle N+2 with coll_new_id=new id, coll_old_id=old id.
  - Same id → no event.
- **coll_count:**
  - +1 per event, saturates at 255.
  - count_clr has priority over an increment in the same cycle; result is 0.
- **Throughput:** one pixel per cycle. Back-to-back identical X uses forwarding, so an A,B sequence at the same X reports (B,A).
- **CLEAR:** buf_wr_b=1, buf_addr_b=counter, buf_wr_data_b=0; counter increments 0 → 2^ADDR_WIDTH-1 and wraps to 0 on exit.
- **Stage 1 and CLEAR are mutually exclusive** by construction: FLUSH guarantees stage 1 is empty before CLEAR starts.
- **Reset mid-CLEAR:** abort to IDLE, no clear_done; buffer contents undefined.
- **Reset mid-pixel:** stage 1 dropped, no write, no event.

Optional Feature:
- Macro: COLL_FIRST_WINS_EN.
- Defined: if old is occupied by a different id, the stage-1 write is suppressed (buf_wr_b=0). The first sprite keeps the pixel, and forwarding uses the retained value. The collision is still reported.
- Undefined: last writer always overwrites.

Test Plan:
- Clear then pixels id 3 at x=5 and id 7 at x=9 → no coll_valid; buffer[5]=0x103, buffer[9]=0x107.
- id 3 at x=5, later id 7 at x=5 → coll_valid pulse 2 cycles after the second accept, new=7, old=3, coll_count=1. Same id 3 at x=5 twice → no event.
- Back-to-back same cycle-pair: id 1 x=20 then id 2 x=20 → event new=2 old=1 via forwarding. Under COLL_FIRST_WINS_EN, buffer[20]=0x101; otherwise 0x102.
- clear_req with a pixel in stage 1 → that pixel's write lands first; then 1024 consecutive zero writes to 0..1023; clear_done one cycle after the last; pix_ready low throughout FLUSH/CLEAR.
- 300 collisions → coll_count=255. count_clr asserted concurrently with an event → 0.
- reset asserted at clear counter=500 → next cycle busy=0, buf_wr_b=0, no clear_done; pixels accepted immediately after reset deasserts.
